inst_realigner: RTL and testbench
=================================

Name: inst_realigner

Overview:
- Fetch-side front end that sits directly upstream of the 16→32-bit decompressor.
- Accepts aligned 32-bit words from instruction memory/cache and buffers them as halfwords.
- Emits one instruction per handshake, either a 16-bit compressed instruction or a full 32-bit instruction, together with its PC and a compressed flag.
- Handles 32-bit instructions that straddle a word boundary, and handles redirects (flush) to any halfword-aligned PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset; must be halfword aligned.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  one-cycle redirect request.
- flush_pc  input  32  redirect target; bit0 is ignored.
- fetch_req  output  1  memory request; held high until the response arrives.
- fetch_addr  output  32  word-aligned request address; bits[1:0] are always 0.
- fetch_valid  input  1  response strobe; completes the outstanding request.
- fetch_data  input  32  response word; little-endian, halfword0 = bits[15:0].
- inst_valid  output  1  instruction available at the output.
- inst_ready  input  1  downstream accepts the instruction.
- inst_raw  output  32  instruction; for compressed, {16'b0, halfword}.
- inst_c  output  1  1 = compressed (inst_raw[1:0] != 2'b11).
- inst_pc  output  32  PC of the presented instruction.

Behaviour:
- Storage: 4-entry halfword buffer (hb0 = head), count 0..4, head_pc, next_fetch_pc, drop_lo flag, kill flag.
- Reset (async):
  - count = 0, head_pc = RESET_PC.
  - next_fetch_pc = RESET_PC & ~3, drop_lo = RESET_PC[1], kill = 0.
  - fetch_req = 0, inst_valid = 0, inst_raw = 0, inst_c = 0, inst_pc = RESET_PC.
- Request FSM, states IDLE and WAIT:
  - IDLE→WAIT when count <= 2 and no flush this cycle. fetch_req goes high next cycle with fetch_addr = next_fetch_pc.
  - In WAIT, fetch_req and fetch_addr are held stable.
  - WAIT→IDLE on fetch_valid. Only one request is ever outstanding; fetch_valid in IDLE is ignored.
  - The first fetch_req rises in the first cycle after reset release.
- Fill on an accepted fetch_valid with kill = 0:
  - If drop_lo = 1: append halfword1 only (+1) and clear drop_lo.
  - Otherwise: append halfword0 then halfword1 (+2).
  - Then next_fetch_pc += 4.
  - The count <= 2 request rule guarantees no overflow, including when a fill and a consume happen in the same cycle.
- Output (combinational from the buffer):
  - hb0[1:0] != 2'b11 and count >= 1 → inst_valid = 1, inst_c = 1.
  - hb0[1:0] == 2'b11 and count >= 2 → inst_valid = 1, inst_c = 0, inst_raw = {hb1, hb0}.
  - hb0[1:0] == 2'b11 and count == 1 → inst_valid = 0. This is the straddle case: wait for the next word.
  - inst_pc = head_pc.
- Consume on inst_valid & inst_ready:
  - Shift by 1 halfword (compressed) or 2 halfwords (32-bit).
  - head_pc += 2 or 4.
  - A consume and a fill in the same cycle compose: count_next = count − consumed + filled.
- Stall: while inst_valid = 1 and inst_ready = 0, inst_raw, inst_c and inst_pc stay stable.
- Flush (highest priority):
  - count = 0, head_pc = {flush_pc[31:1], 1'b0}, next_fetch_pc = flush_pc & ~3, drop_lo = flush_pc[1].
  - inst_valid is forced 0 in the cycle after the flush; any consume in the flush cycle is discarded.
  - If in WAIT and fetch_valid is not present in the same cycle: set kill = 1. The pending response is discarded on arrival, kill clears, FSM → IDLE, then the new request is issued.
  - If fetch_valid coincides with flush, that word is discarded.
  - Back-to-back flushes: the last one wins.
- PC arithmetic is 32-bit modulo; 0xFFFF_FFFC + 4 wraps to 0.

Test Plan:
- Aligned 32-bit: RESET_PC = 0, mem[0] = 32'h0000_0013 → fetch_addr 0; then inst_valid, inst_raw 32'h0000_0013, inst_c 0, inst_pc 0.
- Two compressed instructions: mem[0] = 32'h0001_0505 → first inst_raw 32'h0000_0505, c = 1, pc 0; then inst_raw 32'h0000_0001, c = 1, pc 2.
- Straddle: mem[0] = 32'h0013_0001, mem[4] = 32'h0001_0000:
  - First: pc 0 c.nop.
  - Then inst_valid stays 0 until the mem[4] response.
  - Then inst_raw 32'h0000_0013, c = 0, pc 2.
  - Then pc 6 inst_raw 32'h0000_0001, c = 1.
- Flush while outstanding: memory latency 3, flush_pc = 32'h0000_0102 during WAIT:
  - Old response discarded; no instruction from it.
  - Next fetch_addr 32'h100; halfword at 0x100 dropped; first inst_pc 32'h102.
- Backpressure: inst_ready = 0 for 8 cycles with a stream of 16-bit instructions:
  - Outputs stable.
  - count reaches 4 at most.
  - fetch_req stays low while count > 2.
  - After release, instructions at consecutive PCs with none lost.
- Reset mid-WAIT: assert rst_n low → fetch_req and inst_valid are 0 immediately; after release, fetch_addr = RESET_PC & ~3.

Source files
------------

// File: rtl/inst_realigner.sv
// rtl/inst_realigner.sv - fetch-side realigner turning aligned words into 16/32-bit instructions
module inst_realigner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_raw,
    output logic        inst_c,
    output logic [31:0] inst_pc
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_nxt;
    logic [15:0] hb     [4];
    logic [15:0] hb_nxt [4];
    logic [2:0]  count, count_nxt;
    logic [31:0] head_pc, next_fetch_pc;
    logic        drop_lo, kill, kill_nxt;
    logic        head_c, fill, consume;
    logic [1:0]  used, filled, base;

    assign head_c     = hb[0][1:0] != 2'b11;
    assign inst_valid = head_c ? (count >= 3'd1) : (count >= 3'd2);
    assign inst_c     = inst_valid & head_c;
    assign inst_raw   = !inst_valid ? 32'h0 : head_c ? {16'h0, hb[0]} : {hb[1], hb[0]};
    assign inst_pc    = head_pc;
    assign fetch_req  = (state == WAIT);

    // A flush discards any same-cycle consume or fill.
    assign consume   = inst_valid & inst_ready & ~flush;
    assign used      = !consume ? 2'd0 : head_c ? 2'd1 : 2'd2;
    assign fill      = (state == WAIT) & fetch_valid & ~kill & ~flush;
    assign filled    = !fill ? 2'd0 : drop_lo ? 2'd1 : 2'd2;
    assign base      = count[1:0] - used;
    assign count_nxt = count - {1'b0, used} + {1'b0, filled};

    // Shift out consumed halfwords, then append the fill behind what remains.
    always_comb begin
        for (int i = 0; i < 4; i++) hb_nxt[i] = hb[i];
        if (used == 2'd1) begin
            hb_nxt[0] = hb[1];
            hb_nxt[1] = hb[2];
            hb_nxt[2] = hb[3];
        end else if (used == 2'd2) begin
            hb_nxt[0] = hb[2];
            hb_nxt[1] = hb[3];
        end
        if (fill) begin
            if (drop_lo) begin
                hb_nxt[base] = fetch_data[31:16];
            end else begin
                hb_nxt[base]         = fetch_data[15:0];
                hb_nxt[base + 2'd1]  = fetch_data[31:16];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        kill_nxt  = kill;
        case (state)
            IDLE: if (!flush && count <= 3'd2) state_nxt = WAIT;
            WAIT: begin
                if (fetch_valid) begin
                    state_nxt = IDLE;
                    kill_nxt  = 1'b0;
                end else if (flush) begin
                    kill_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            kill          <= 1'b0;
            count         <= 3'd0;
            head_pc       <= RESET_PC;
            next_fetch_pc <= RESET_PC & ~32'd3;
            drop_lo       <= RESET_PC[1];
            fetch_addr    <= RESET_PC & ~32'd3;
            for (int i = 0; i < 4; i++) hb[i] <= 16'h0;
        end else begin
            state <= state_nxt;
            kill  <= kill_nxt;
            if (state == IDLE && state_nxt == WAIT) fetch_addr <= next_fetch_pc & ~32'd3;
            for (int i = 0; i < 4; i++) hb[i] <= hb_nxt[i];
            if (flush) begin
                count         <= 3'd0;
                head_pc       <= flush_pc & ~32'd1;
                next_fetch_pc <= flush_pc & ~32'd3;
                drop_lo       <= flush_pc[1];
            end else begin
                count   <= count_nxt;
                head_pc <= head_pc + {29'd0, used, 1'b0};
                if (fill) begin
                    next_fetch_pc <= next_fetch_pc + 32'd4;
                    drop_lo       <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_realigner.sv
// tb/tb_inst_realigner.sv - randomized and directed bench for inst_realigner
module tb_inst_realigner;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n, flush, fetch_req, fetch_valid, inst_valid, inst_ready, inst_c;
    logic [31:0] flush_pc, fetch_addr, fetch_data, inst_raw, inst_pc;

    logic [31:0] mem [1024];
    int          n_checks = 0, n_fail = 0, n_acc = 0, resp_cnt = 0;
    int          lat_fix = 0, cur_lat = 0, wcnt = 0;
    bit          lat_rand = 0, spur = 0, busy = 0;

    inst_realigner #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
        .fetch_data(fetch_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_raw(inst_raw), .inst_c(inst_c), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[11:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Instruction the stream must present at pc: 32-bit iff low bits are 11.
    function automatic logic [31:0] exp_raw(input logic [31:0] pc);
        logic [15:0] lo;
        lo = hw_at(pc);
        if (lo[1:0] == 2'b11) return {hw_at(pc + 32'd2), lo};
        return {16'h0, lo};
    endfunction

    // Memory responder: one response per request after a chosen latency.
    initial begin
        fetch_valid = 1'b0;
        fetch_data  = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                fetch_valid = 1'b0;
                busy = 0;
            end else if (fetch_valid) begin
                fetch_valid = 1'b0;
            end else if (fetch_req) begin
                if (!busy) begin
                    busy = 1;
                    wcnt = 0;
                    cur_lat = lat_rand ? int'($urandom_range(0, 3)) : lat_fix;
                end
                if (wcnt >= cur_lat) begin
                    fetch_valid = 1'b1;
                    fetch_data  = mem[fetch_addr[11:2]];
                    busy = 0;
                    resp_cnt++;
                end else begin
                    wcnt++;
                end
            end else if (spur && $urandom_range(0, 7) == 0) begin
                fetch_valid = 1'b1;
                fetch_data  = $urandom;
            end
        end
    end

    logic [31:0] mpc, praw, ppc, paddr, er;
    logic        pv, pready, pflush, pc_prev, preq, pfv;

    always @(negedge clk) begin
        if (!rst_n) begin
            mpc = RESET_PC;
            pv = 0; pready = 0; pflush = 0; preq = 0; pfv = 0;
        end else begin
            er = 32'h0;
            if (pflush) chk("no_inst_after_flush", {31'b0, inst_valid}, 32'd0);
            if (pv && !pready && !pflush) begin
                chk("stall_valid", {31'b0, inst_valid}, 32'd1);
                chk("stall_raw", inst_raw, praw);
                chk("stall_c", {31'b0, inst_c}, {31'b0, pc_prev});
                chk("stall_pc", inst_pc, ppc);
            end
            if (preq && !pfv) begin
                chk("req_hold", {31'b0, fetch_req}, 32'd1);
                chk("addr_hold", fetch_addr, paddr);
            end
            if (fetch_req) chk("addr_align", {30'b0, fetch_addr[1:0]}, 32'd0);
            if (inst_valid) begin
                er = exp_raw(mpc);
                chk("model_pc", inst_pc, mpc);
                chk("model_raw", inst_raw, er);
                chk("model_c", {31'b0, inst_c}, {31'b0, er[1:0] != 2'b11});
            end
            if (flush) begin
                mpc = flush_pc & ~32'd1;
            end else if (inst_valid && inst_ready) begin
                n_acc++;
                mpc = mpc + ((er[1:0] != 2'b11) ? 32'd2 : 32'd4);
            end
            pv = inst_valid; pready = inst_ready; pflush = flush; praw = inst_raw;
            pc_prev = inst_c; ppc = inst_pc; preq = fetch_req; pfv = fetch_valid; paddr = fetch_addr;
        end
    end

    task automatic reset_begin();
        @(posedge clk); #1;
        rst_n = 1'b0; flush = 1'b0; inst_ready = 1'b1; lat_rand = 0; spur = 0;
        #1;
        chk("rst_fetch_req", {31'b0, fetch_req}, 32'd0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst_raw", inst_raw, 32'd0);
        chk("rst_inst_c", {31'b0, inst_c}, 32'd0);
        chk("rst_inst_pc", inst_pc, RESET_PC);
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0001_0001;
    endtask

    task automatic reset_end();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_inst(input string name, output bit ok);
        ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (inst_valid) ok = 1;
        end
        chk({name, "_seen"}, {31'b0, ok}, 32'd1);
    endtask

    task automatic expect_inst(input string name, input logic [31:0] raw, input logic c,
                               input logic [31:0] pc);
        bit ok;
        wait_inst(name, ok);
        if (ok) begin
            chk({name, "_raw"}, inst_raw, raw);
            chk({name, "_c"}, {31'b0, inst_c}, {31'b0, c});
            chk({name, "_pc"}, inst_pc, pc);
        end
    endtask

    task automatic wait_req(input logic lvl, input string name);
        bit ok;
        ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (fetch_req == lvl) ok = 1;
        end
        chk(name, {31'b0, ok}, 32'd1);
    endtask

    initial begin
        int resp0;
        logic [13:0] a;
        rst_n = 1'b0; flush = 1'b0; flush_pc = 32'h0; inst_ready = 1'b1;

        // Aligned 32-bit instruction
        reset_begin();
        lat_fix = 0;
        mem[0] = 32'h0000_0013;
        reset_end();
        @(posedge clk); #1;
        chk("t1_first_req", {31'b0, fetch_req}, 32'd1);
        chk("t1_first_addr", fetch_addr, 32'h0);
        expect_inst("t1a", 32'h0000_0013, 1'b0, 32'h0);
        expect_inst("t1b", 32'h0000_0001, 1'b1, 32'h4);

        // Two compressed instructions in one word
        reset_begin();
        mem[0] = 32'h0001_0505;
        reset_end();
        expect_inst("t2a", 32'h0000_0505, 1'b1, 32'h0);
        expect_inst("t2b", 32'h0000_0001, 1'b1, 32'h2);

        // 32-bit instruction straddling a word boundary
        reset_begin();
        lat_fix = 3;
        mem[0] = 32'h0013_0001;
        mem[1] = 32'h0001_0000;
        resp0 = resp_cnt;
        reset_end();
        expect_inst("t3a", 32'h0000_0001, 1'b1, 32'h0);
        expect_inst("t3b", 32'h0000_0013, 1'b0, 32'h2);
        chk("t3_waited", {31'b0, (resp_cnt - resp0) >= 2}, 32'd1);
        expect_inst("t3c", 32'h0000_0001, 1'b1, 32'h6);

        // Flush while a request is outstanding
        reset_begin();
        lat_fix = 3;
        mem[0]  = 32'h0505_0505;
        mem[64] = 32'h0009_0001;
        reset_end();
        @(posedge clk); #1;
        chk("t4_wait", {31'b0, fetch_req}, 32'd1);
        flush = 1'b1; flush_pc = 32'h0000_0102;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_req(1'b0, "t4_req_drop");
        wait_req(1'b1, "t4_req_new");
        chk("t4_addr", fetch_addr, 32'h0000_0100);
        expect_inst("t4", 32'h0000_0009, 1'b1, 32'h0000_0102);

        // Backpressure on a compressed stream
        reset_begin();
        lat_fix = 0;
        for (int i = 0; i < 16; i++) begin
            a = 14'(2 * i);
            mem[i] = {a + 14'd1, 2'b01, a, 2'b01};
        end
        inst_ready = 1'b0;
        reset_end();
        expect_inst("t5_first", 32'h0000_0001, 1'b1, 32'h0);
        repeat (8) @(negedge clk);
        chk("t5_req_low", {31'b0, fetch_req}, 32'd0);
        chk("t5_held_valid", {31'b0, inst_valid}, 32'd1);
        chk("t5_held_pc", inst_pc, 32'h0);
        @(posedge clk); #1;
        inst_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a = 14'(k);
            expect_inst("t5_rel", {16'h0, a, 2'b01}, 1'b1, 32'(2 * k));
        end

        // Reset while waiting on memory
        reset_begin();
        lat_fix = 3;
        reset_end();
        @(posedge clk); #1;
        chk("t6_wait", {31'b0, fetch_req}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t6_req_async", {31'b0, fetch_req}, 32'd0);
        chk("t6_valid_async", {31'b0, inst_valid}, 32'd0);
        reset_end();
        @(posedge clk); #1;
        chk("t6_req_again", {31'b0, fetch_req}, 32'd1);
        chk("t6_addr", fetch_addr, RESET_PC & ~32'd3);

        // Random traffic, random latency, flushes and stray responses
        reset_begin();
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 1) == 0) w[1:0] = 2'b11;
            else w[1:0] = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0) w[17:16] = 2'b11;
            else w[17:16] = 2'($urandom_range(0, 2));
            mem[i] = w;
        end
        lat_rand = 1; spur = 1;
        resp0 = n_acc;
        reset_end();
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                flush = 1'b1;
                flush_pc = (($urandom_range(0, 3) == 0) ? 32'hFFFF_F000 : 32'h0) | ($urandom & 32'hFFF);
            end else begin
                flush = 1'b0;
            end
        end
        @(posedge clk); #1;
        flush = 1'b0; spur = 0;
        repeat (4) @(posedge clk);
        chk("rand_progress", {31'b0, (n_acc - resp0) > 300}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
